// File: rtl/secondary_slot_pkg.sv
// secondary_slot_pkg: state encoding, register address and sub-slot field decode shared by the slot controller
package secondary_slot_pkg;
    typedef enum logic [1:0] {IDLE, ACK, RDWAIT, RELEASE} state_t;
    localparam logic [15:0] SUBSLOT_REG_ADDR = 16'hFFFF;
    function automatic logic [1:0] subslot_of(input logic [7:0] r, input logic [1:0] page);
        return r[{page, 1'b0} +: 2];
    endfunction
endpackage

// File: rtl/secondary_slot_multi_if.sv
// secondary_slot_multi_if: internal-bus side of the expanded-slot controller plus the decoded sub-slot selects
interface secondary_slot_multi_if #(parameter int NUM_SLOTS = 4);
    logic [NUM_SLOTS-1:0]   bus_sltsl;
    logic                   bus_memory_req;
    logic                   bus_ack;
    logic                   bus_wrt;
    logic [15:0]            bus_address;
    logic [7:0]             bus_wdata;
    logic [7:0]             bus_rdata;
    logic                   bus_rdata_en;
    logic [NUM_SLOTS*4-1:0] sltsl_ext;
    modport master (
        output bus_sltsl, bus_memory_req, bus_wrt, bus_address, bus_wdata,
        input  bus_ack, bus_rdata, bus_rdata_en, sltsl_ext
    );
    modport slave (
        input  bus_sltsl, bus_memory_req, bus_wrt, bus_address, bus_wdata,
        output bus_ack, bus_rdata, bus_rdata_en, sltsl_ext
    );
endinterface

// File: rtl/secondary_slot_channel.sv
// secondary_slot_channel: one primary slot's sub-slot register and its 4-way select decode
module secondary_slot_channel
    import secondary_slot_pkg::*;
#(
    parameter bit         EXPANDED    = 1'b1,
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic       sel_en,
    input  logic       hide,
    input  logic [1:0] page,
    input  logic [7:0] wdata,
    output logic [7:0] value,
    output logic [3:0] sel
);
    always_ff @(posedge clk) begin
        if (reset) value <= RESET_VALUE;
        else if (we) value <= wdata;
    end
    // a pass-through slot always maps to sub-slot 0
    always_comb sel = (sel_en && !hide) ? 4'b0001 << (EXPANDED ? subslot_of(value, page) : 2'd0) : 4'b0000;
endmodule

// File: rtl/secondary_slot_multi.sv
// secondary_slot_multi: MSX expanded-slot controller; define SECONDARY_SLOT_READBACK_EN to also claim FFFFh reads
module secondary_slot_multi
    import secondary_slot_pkg::*;
#(
    parameter int         NUM_SLOTS     = 4,
    parameter logic [3:0] SLOT_EXPANDED = 4'b1111,
    parameter logic [7:0] RESET_VALUE   = 8'h00,
    parameter int         RD_LATENCY    = 1
) (
    input logic                  clk,
    input logic                  reset,
    secondary_slot_multi_if.slave bus
);
`ifdef SECONDARY_SLOT_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif
    state_t               state, state_nx;
    logic [1:0]           cnt;
    logic                 at_reg, claim, rd_txn;
    logic [NUM_SLOTS-1:0] hit, win;
    logic [7:0]           regs [NUM_SLOTS];
    logic [7:0]           rd_sel, rdata_q;

    assign at_reg = bus.bus_address == SUBSLOT_REG_ADDR;
    assign win    = hit & (~hit + NUM_SLOTS'(1));
    assign claim  = state == IDLE && |hit;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_ch
        assign hit[i] = bus.bus_memory_req && bus.bus_sltsl[i] && SLOT_EXPANDED[i] && at_reg
                        && (bus.bus_wrt || READBACK);
        secondary_slot_channel #(
            .EXPANDED    (SLOT_EXPANDED[i]),
            .RESET_VALUE (RESET_VALUE)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .we     (claim && bus.bus_wrt && win[i]),
            .sel_en (bus.bus_memory_req && bus.bus_sltsl[i]),
            .hide   (hit[i]),
            .page   (bus.bus_address[15:14]),
            .wdata  (bus.bus_wdata),
            .value  (regs[i]),
            .sel    (bus.sltsl_ext[i*4 +: 4])
        );
    end

    always_comb begin
        rd_sel = 8'h00;
        for (int j = 0; j < NUM_SLOTS; j++) rd_sel |= win[j] ? regs[j] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            rd_txn  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state <= state_nx;
            cnt   <= state == ACK ? 2'(RD_LATENCY - 1) : cnt - (state == RDWAIT ? 2'd1 : 2'd0);
            if (claim) rd_txn <= !bus.bus_wrt;
            if (claim && !bus.bus_wrt) rdata_q <= ~rd_sel;
        end
    end

    // RELEASE waits for the requester to drop its strobe so a held request is claimed once
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = claim ? ACK : IDLE;
            ACK:     state_nx = rd_txn ? RDWAIT : RELEASE;
            RDWAIT:  state_nx = cnt == 2'd0 ? RELEASE : RDWAIT;
            RELEASE: state_nx = bus.bus_memory_req ? RELEASE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.bus_ack      = state == ACK;
    assign bus.bus_rdata_en = state == RDWAIT && cnt == 2'd0;
    assign bus.bus_rdata    = bus.bus_rdata_en ? rdata_q : 8'h00;
endmodule

// File: tb/tb_secondary_slot_multi.sv
// tb_secondary_slot_multi: directed checks on default, RD_LATENCY=3 and SLOT_EXPANDED=4'b1110 instances
module tb_secondary_slot_multi;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sltsl = 4'h0;
    logic        req = 1'b0, wrt = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    int cmp = 0, bad = 0;

    always #5 clk = ~clk;

    secondary_slot_multi_if #(.NUM_SLOTS(4)) bm ();
    secondary_slot_multi_if #(.NUM_SLOTS(4)) bl ();
    secondary_slot_multi_if #(.NUM_SLOTS(4)) bn ();

    assign bm.bus_sltsl = sltsl; assign bm.bus_memory_req = req; assign bm.bus_wrt = wrt;
    assign bm.bus_address = addr; assign bm.bus_wdata = wdata;
    assign bl.bus_sltsl = sltsl; assign bl.bus_memory_req = req; assign bl.bus_wrt = wrt;
    assign bl.bus_address = addr; assign bl.bus_wdata = wdata;
    assign bn.bus_sltsl = sltsl; assign bn.bus_memory_req = req; assign bn.bus_wrt = wrt;
    assign bn.bus_address = addr; assign bn.bus_wdata = wdata;

    secondary_slot_multi dut_m (.clk(clk), .reset(reset), .bus(bm));
    secondary_slot_multi #(.RD_LATENCY(3)) dut_l (.clk(clk), .reset(reset), .bus(bl));
    secondary_slot_multi #(.SLOT_EXPANDED(4'b1110)) dut_n (.clk(clk), .reset(reset), .bus(bn));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic do_write(input int s, input logic [7:0] d);
        int n;
        sltsl = 4'(1 << s); wrt = 1'b1; addr = 16'hFFFF; wdata = d; req = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!bm.bus_ack && n < 8);
        cmp++;
        if (bm.bus_ack !== 1'b1) begin bad++; $display("FAIL write_ack slot %0d: ack=%b want 1", s, bm.bus_ack); end
        req = 1'b0;
        cyc(); cyc();
    endtask

    task automatic do_read(input int s, output logic [7:0] d, output logic seen);
        sltsl = 4'(1 << s); wrt = 1'b0; addr = 16'hFFFF; req = 1'b1; seen = 1'b0; d = 8'hxx;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (bm.bus_rdata_en) begin seen = 1'b1; d = bm.bus_rdata; end
        end
        req = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset();
        do_reset();
        cmp++;
        if (bm.bus_ack !== 1'b0 || bm.bus_rdata_en !== 1'b0 || bm.bus_rdata !== 8'h00) begin
            bad++; $display("FAIL reset_outputs: ack=%b en=%b rdata=%h want 0/0/00", bm.bus_ack, bm.bus_rdata_en, bm.bus_rdata);
        end
        cmp++;
        if (bm.sltsl_ext !== 16'h0000) begin bad++; $display("FAIL reset_idle_sel: got %h want 0000", bm.sltsl_ext); end
        sltsl = 4'b0001; wrt = 1'b0; addr = 16'h0000; req = 1'b1;
        #1;
        cmp++;
        if (bm.sltsl_ext !== 16'h0001) begin bad++; $display("FAIL reset_sel: got %h want 0001", bm.sltsl_ext); end
        req = 1'b0;
        cyc();
    endtask

    task automatic test_write_read();
        logic [7:0] vals [6];
        logic [7:0] v, d;
        logic [15:0] e;
        logic seen;
        vals = '{8'h12, 8'h23, 8'h34, 8'h56, 8'hAF, 8'h9A};
        for (int s = 0; s < 4; s++) begin
            for (int n = 0; n < 6; n++) begin
                v = vals[n];
                do_write(s, v);
                sltsl = 4'(1 << s); wrt = 1'b0; req = 1'b1; addr = 16'h0000;
                #1;
                e = 16'h0000; e[s*4 + int'(v[1:0])] = 1'b1;
                cmp++;
                if (bm.sltsl_ext !== e) begin bad++; $display("FAIL wr_sel_p0 slot %0d val %h: got %h want %h", s, v, bm.sltsl_ext, e); end
                addr = 16'h8000;
                #1;
                e = 16'h0000; e[s*4 + int'(v[5:4])] = 1'b1;
                cmp++;
                if (bm.sltsl_ext !== e) begin bad++; $display("FAIL wr_sel_p2 slot %0d val %h: got %h want %h", s, v, bm.sltsl_ext, e); end
                req = 1'b0;
                cyc();
`ifdef SECONDARY_SLOT_READBACK_EN
                do_read(s, d, seen);
                cmp++;
                if (seen !== 1'b1 || d !== ~v) begin bad++; $display("FAIL readback slot %0d: en=%b rdata=%h want 1/%h", s, seen, d, ~v); end
`endif
            end
        end
    endtask

    task automatic test_page_decode();
        logic [3:0] e;
        do_write(0, 8'hE4);
        sltsl = 4'b0001; wrt = 1'b0; req = 1'b1;
        for (int p = 0; p < 4; p++) begin
            addr = 16'(p << 14);
            e = 4'(1 << p);
            #1;
            cmp++;
            if (bm.sltsl_ext[3:0] !== e) begin bad++; $display("FAIL page_e4 p%0d: got %b want %b", p, bm.sltsl_ext[3:0], e); end
        end
        req = 1'b0;
        cyc();
        do_write(0, 8'h1B);
        sltsl = 4'b0001; wrt = 1'b0; req = 1'b1;
        for (int p = 0; p < 4; p++) begin
            addr = 16'(p << 14);
            e = 4'(8 >> p);
            #1;
            cmp++;
            if (bm.sltsl_ext[3:0] !== e) begin bad++; $display("FAIL page_1b p%0d: got %b want %b", p, bm.sltsl_ext[3:0], e); end
        end
        req = 1'b0;
        cyc();
    endtask

    task automatic test_cross_slot();
        do_reset();
        do_write(1, 8'hFF);
        sltsl = 4'b0001; wrt = 1'b0; addr = 16'hC000; req = 1'b1;
        #1;
        cmp++;
        if (bm.sltsl_ext !== 16'h0001) begin bad++; $display("FAIL cross_slot0: got %h want 0001", bm.sltsl_ext); end
        sltsl = 4'b0010;
        #1;
        cmp++;
        if (bm.sltsl_ext !== 16'h0080) begin bad++; $display("FAIL cross_slot1: got %h want 0080", bm.sltsl_ext); end
        req = 1'b0;
        cyc();
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        sltsl = 4'b0011; wrt = 1'b1; addr = 16'hFFFF; wdata = 8'h02; req = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!bm.bus_ack && n < 8);
        cmp++;
        if (bm.bus_ack !== 1'b1) begin bad++; $display("FAIL prio_ack: ack=%b want 1", bm.bus_ack); end
        req = 1'b0;
        cyc(); cyc();
        sltsl = 4'b0011; wrt = 1'b0; addr = 16'h0000; req = 1'b1;
        #1;
        cmp++;
        if (bm.sltsl_ext !== 16'h0014) begin bad++; $display("FAIL prio_sel: got %h want 0014", bm.sltsl_ext); end
        req = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        int acks;
        do_reset();
        sltsl = 4'b0001; wrt = 1'b1; addr = 16'hFFFF; wdata = 8'h03; req = 1'b1;
        acks = 0;
        for (int k = 0; k < 8; k++) begin cyc(); acks += int'(bm.bus_ack); end
        cmp++;
        if (acks !== 1) begin bad++; $display("FAIL held_one_ack: acks=%0d want 1", acks); end
        sltsl = 4'b0010; wdata = 8'h55;
        acks = 0;
        for (int k = 0; k < 6; k++) begin cyc(); acks += int'(bm.bus_ack); end
        cmp++;
        if (acks !== 0) begin bad++; $display("FAIL busy_no_ack: acks=%0d want 0", acks); end
        req = 1'b0;
        cyc();
        req = 1'b1;
        acks = 0;
        for (int k = 0; k < 4; k++) begin cyc(); acks += int'(bm.bus_ack); end
        cmp++;
        if (acks !== 1) begin bad++; $display("FAIL after_idle_ack: acks=%0d want 1", acks); end
        req = 1'b0;
        cyc(); cyc();
        sltsl = 4'b0011; wrt = 1'b0; addr = 16'h0000; req = 1'b1;
        #1;
        cmp++;
        if (bm.sltsl_ext !== 16'h0028) begin bad++; $display("FAIL b2b_sel: got %h want 0028", bm.sltsl_ext); end
        req = 1'b0;
        cyc();
    endtask

    task automatic test_nonexpanded();
        int acks;
        do_reset();
        sltsl = 4'b0001; wrt = 1'b1; addr = 16'hFFFF; wdata = 8'hE4; req = 1'b1;
        #1;
        cmp++;
        if (bn.sltsl_ext[3:0] !== 4'b0001) begin bad++; $display("FAIL ne_follow: got %b want 0001", bn.sltsl_ext[3:0]); end
        cmp++;
        if (bm.sltsl_ext[3:0] !== 4'b0000) begin bad++; $display("FAIL claimed_hidden: got %b want 0000", bm.sltsl_ext[3:0]); end
        acks = 0;
        for (int k = 0; k < 6; k++) begin cyc(); acks += int'(bn.bus_ack); end
        cmp++;
        if (acks !== 0) begin bad++; $display("FAIL ne_no_ack: acks=%0d want 0", acks); end
        addr = 16'hC000;
        #1;
        cmp++;
        if (bn.sltsl_ext[3:0] !== 4'b0001) begin bad++; $display("FAIL ne_page3: got %b want 0001", bn.sltsl_ext[3:0]); end
        req = 1'b0;
        #1;
        cmp++;
        if (bn.sltsl_ext[3:0] !== 4'b0000) begin bad++; $display("FAIL ne_idle: got %b want 0000", bn.sltsl_ext[3:0]); end
        cyc(); cyc();
    endtask

`ifdef SECONDARY_SLOT_READBACK_EN
    task automatic test_latency();
        int ta, tr, acks;
        logic [7:0] d;
        do_reset();
        do_write(2, 8'h5A);
        sltsl = 4'b0100; wrt = 1'b0; addr = 16'hFFFF; req = 1'b1;
        ta = -1; tr = -1; acks = 0; d = 8'h00;
        #1;
        cmp++;
        if (bm.sltsl_ext !== 16'h0000) begin bad++; $display("FAIL rd_hidden: got %h want 0000", bm.sltsl_ext); end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            acks += int'(bm.bus_ack);
            if (bl.bus_ack && ta < 0) ta = k;
            if (bl.bus_rdata_en && tr < 0) begin tr = k; d = bl.bus_rdata; end
        end
        cmp++;
        if (ta < 0 || tr - ta !== 3) begin bad++; $display("FAIL lat3: ack@%0d en@%0d want distance 3", ta, tr); end
        cmp++;
        if (d !== 8'hA5) begin bad++; $display("FAIL lat3_data: got %h want a5", d); end
        cmp++;
        if (acks !== 1) begin bad++; $display("FAIL rd_one_ack: acks=%0d want 1", acks); end
        req = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset_rdwait();
        int evs;
        logic [7:0] d;
        logic seen;
        do_reset();
        do_write(2, 8'h3C);
        sltsl = 4'b0100; wrt = 1'b0; addr = 16'hFFFF; req = 1'b1;
        cyc();
        cmp++;
        if (bl.bus_ack !== 1'b1) begin bad++; $display("FAIL rst_pre_ack: ack=%b want 1", bl.bus_ack); end
        cyc();
        reset = 1'b1; req = 1'b0;
        cyc();
        reset = 1'b0;
        evs = 0;
        for (int k = 0; k < 6; k++) begin cyc(); evs += int'(bl.bus_rdata_en) + int'(bl.bus_ack); end
        cmp++;
        if (evs !== 0) begin bad++; $display("FAIL rst_no_strobe: strobes=%0d want 0", evs); end
        do_read(2, d, seen);
        cmp++;
        if (seen !== 1'b1 || d !== 8'hFF) begin bad++; $display("FAIL rst_readback: en=%b rdata=%h want 1/ff", seen, d); end
    endtask
`else
    task automatic test_no_readback();
        int acks, ens;
        do_reset();
        do_write(0, 8'hC0);
        sltsl = 4'b0001; wrt = 1'b0; addr = 16'hFFFF; req = 1'b1;
        #1;
        cmp++;
        if (bm.sltsl_ext[3:0] !== 4'b1000) begin bad++; $display("FAIL nrb_sel: got %b want 1000", bm.sltsl_ext[3:0]); end
        acks = 0; ens = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            acks += int'(bm.bus_ack) + int'(bl.bus_ack);
            ens += int'(bm.bus_rdata_en) + int'(bl.bus_rdata_en) + int'(bm.bus_rdata != 8'h00);
        end
        cmp++;
        if (acks !== 0) begin bad++; $display("FAIL nrb_no_ack: acks=%0d want 0", acks); end
        cmp++;
        if (ens !== 0) begin bad++; $display("FAIL nrb_no_rdata: events=%0d want 0", ens); end
        req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_midwrite();
        int acks;
        do_reset();
        sltsl = 4'b0001; wrt = 1'b1; addr = 16'hFFFF; wdata = 8'h77; req = 1'b1; reset = 1'b1;
        cyc();
        reset = 1'b0; req = 1'b0;
        acks = 0;
        for (int k = 0; k < 4; k++) begin cyc(); acks += int'(bm.bus_ack); end
        cmp++;
        if (acks !== 0) begin bad++; $display("FAIL rst_wr_no_ack: acks=%0d want 0", acks); end
        addr = 16'h0000; wrt = 1'b0; req = 1'b1;
        #1;
        cmp++;
        if (bm.sltsl_ext[3:0] !== 4'b0001) begin bad++; $display("FAIL rst_wr_sel: got %b want 0001", bm.sltsl_ext[3:0]); end
        req = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_page_decode();
        test_cross_slot();
        test_priority();
        test_back_to_back();
        test_nonexpanded();
`ifdef SECONDARY_SLOT_READBACK_EN
        test_latency();
        test_reset_rdwait();
`else
        test_no_readback();
        test_reset_midwrite();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
